// File: rtl/pe_req_capture.sv
// Request-capture front end for the 8-bit priority encoder: synchronise, edge-detect,
// hold sticky pending bits and offer a frozen masked snapshot. Optional macro: PE_REQ_OVERFLOW_EN.
module pe_req_capture #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n,
    input  logic [7:0] io_req,
    input  logic [7:0] io_mask,
    input  logic       io_en,
    input  logic       io_ack,
    input  logic [2:0] io_ack_idx,
`ifdef PE_REQ_OVERFLOW_EN
    input  logic       ovf_clr,
    output logic [7:0] ovf,
`endif
    output logic [7:0] pend_snap,
    output logic       pend_valid,
    output logic       ack_err,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                        state;
    logic [7:0]                    count;
    logic [SYNC_STAGES-1:0][7:0]   sync_q;
    logic [7:0]                    prev;
    logic [7:0]                    pending;
    logic [7:0]                    sync_out;
    logic [7:0]                    rise;
    logic [7:0]                    masked;
    logic [7:0]                    clr_vec;
    logic [7:0]                    pending_next;
    logic                          ack_hit;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev;
    assign masked   = pending & ~io_mask;
    assign ack_hit  = io_ack & pend_snap[io_ack_idx];

    // Only a matching ack in a live offer clears; a same-cycle edge re-sets the bit.
    always_comb begin
        clr_vec = 8'h00;
        if (state == S_OFFER && io_en && ack_hit)
            clr_vec = 8'h01 << io_ack_idx;
        pending_next = (pending & ~clr_vec) | rise;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_q  <= '0;
            prev    <= 8'h00;
            pending <= 8'h00;
            busy    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], io_req};
            prev    <= sync_out;
            pending <= pending_next;
            busy    <= |pending_next;
        end
    end

`ifdef PE_REQ_OVERFLOW_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n)
            ovf <= 8'h00;
        else
            ovf <= (ovf & ~{8{ovf_clr}}) | (rise & pending & ~clr_vec);
    end
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= S_IDLE;
            count      <= 8'h00;
            pend_snap  <= 8'h00;
            pend_valid <= 1'b0;
            ack_err    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            ack_err <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io_en && masked != 8'h00) begin
                        pend_snap  <= masked;
                        pend_valid <= 1'b1;
                        count      <= 8'h00;
                        state      <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (!io_en) begin
                        pend_snap  <= 8'h00;
                        pend_valid <= 1'b0;
                        state      <= S_IDLE;
                    end else if (io_ack || count == TO_LAST) begin
                        // Every exit to GAP drops the vector so the encoder sees a blank cycle.
                        ack_err    <= io_ack & ~ack_hit;
                        timeout    <= ~io_ack;
                        pend_snap  <= 8'h00;
                        pend_valid <= 1'b0;
                        state      <= S_GAP;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                S_GAP: begin
                    pend_snap  <= 8'h00;
                    pend_valid <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    pend_snap  <= 8'h00;
                    pend_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_req_capture.sv
// Directed bench for pe_req_capture (TIMEOUT_CYCLES=4); covers the overflow flags when
// PE_REQ_OVERFLOW_EN is defined.
module tb_pe_req_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       en;
    logic       ack;
    logic [2:0] ack_idx;
    logic [7:0] pend_snap;
    logic       pend_valid;
    logic       ack_err;
    logic       timeout;
    logic       busy;
`ifdef PE_REQ_OVERFLOW_EN
    logic       ovf_clr;
    logic [7:0] ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_req_capture #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .io_req    (req),
        .io_mask   (mask),
        .io_en     (en),
        .io_ack    (ack),
        .io_ack_idx(ack_idx),
`ifdef PE_REQ_OVERFLOW_EN
        .ovf_clr   (ovf_clr),
        .ovf       (ovf),
`endif
        .pend_snap (pend_snap),
        .pend_valid(pend_valid),
        .ack_err   (ack_err),
        .timeout   (timeout),
        .busy      (busy)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 8'h00;
        mask    = 8'h00;
        en      = 1'b0;
        ack     = 1'b0;
        ack_idx = 3'd0;
`ifdef PE_REQ_OVERFLOW_EN
        ovf_clr = 1'b0;
`endif
        tick(3);
        check("rst_snap", pend_snap, 8'h00);
        check("rst_valid", {7'd0, pend_valid}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_err", {7'd0, ack_err}, 8'h00);
        check("rst_to", {7'd0, timeout}, 8'h00);
        rst_n = 1'b1;
        en    = 1'b1;

        // Quiet inputs must never produce an offer.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("quiet_vb", {6'd0, pend_valid, busy}, 8'h00);
            check("quiet_snap", pend_snap, 8'h00);
        end

        // Two-bit request, service bit 5, bit 2 re-offered.
        req = 8'h24;
        tick(3);
        check("lat_busy", {7'd0, busy}, 8'h01);
        check("lat_valid_early", {7'd0, pend_valid}, 8'h00);
        tick(1);
        check("offer1_valid", {7'd0, pend_valid}, 8'h01);
        check("offer1_snap", pend_snap, 8'h24);
        ack = 1'b1; ack_idx = 3'd5;
        tick(1);
        ack = 1'b0;
        check("gap1_valid", {7'd0, pend_valid}, 8'h00);
        check("gap1_snap", pend_snap, 8'h00);
        check("gap1_err", {7'd0, ack_err}, 8'h00);
        tick(2);
        check("offer2_valid", {7'd0, pend_valid}, 8'h01);
        check("offer2_snap", pend_snap, 8'h04);
        ack = 1'b1; ack_idx = 3'd2;
        tick(1);
        ack = 1'b0;
        check("clr_all_busy", {7'd0, busy}, 8'h00);
        req = 8'h00;
        tick(5);

        // Ack on an index not in the snapshot.
        req = 8'h80;
        tick(4);
        check("offer3_snap", pend_snap, 8'h80);
        ack = 1'b1; ack_idx = 3'd3;
        tick(1);
        ack = 1'b0;
        check("err_pulse", {7'd0, ack_err}, 8'h01);
        check("err_valid", {7'd0, pend_valid}, 8'h00);
        tick(1);
        check("err_single", {7'd0, ack_err}, 8'h00);
        tick(1);
        check("reoffer_valid", {7'd0, pend_valid}, 8'h01);
        check("reoffer_snap", pend_snap, 8'h80);
        ack = 1'b1; ack_idx = 3'd7;
        tick(1);
        ack = 1'b0;
        req = 8'h00;
        tick(5);
        check("clean3_busy", {7'd0, busy}, 8'h00);

        // Masked capture, then release of the mask.
        mask = 8'hFF;
        req  = 8'h04;
        tick(4);
        check("mask_busy", {7'd0, busy}, 8'h01);
        check("mask_valid", {7'd0, pend_valid}, 8'h00);
        tick(3);
        check("mask_hold", {7'd0, pend_valid}, 8'h00);
        mask = 8'h00;
        tick(1);
        check("unmask_valid", {7'd0, pend_valid}, 8'h01);
        check("unmask_snap", pend_snap, 8'h04);
        mask = 8'hFF;
        tick(1);
        check("frozen_snap", pend_snap, 8'h04);
        mask = 8'h00;
        ack = 1'b1; ack_idx = 3'd2;
        tick(1);
        ack = 1'b0;
        req = 8'h00;
        tick(5);
        check("clean4_busy", {7'd0, busy}, 8'h00);

        // Offer expiry, re-offer, then disable mid-offer.
        req = 8'h01;
        tick(4);
        check("to_offer_snap", pend_snap, 8'h01);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("to_wait", {6'd0, timeout, pend_valid}, 8'h01);
        end
        tick(1);
        check("to_pulse", {6'd0, timeout, pend_valid}, 8'h02);
        tick(1);
        check("to_single", {7'd0, timeout}, 8'h00);
        tick(1);
        check("to_reoffer", pend_snap, 8'h01);
        check("to_reoffer_v", {7'd0, pend_valid}, 8'h01);
        en = 1'b0;
        tick(1);
        check("dis_valid", {7'd0, pend_valid}, 8'h00);
        check("dis_snap", pend_snap, 8'h00);
        check("dis_busy", {7'd0, busy}, 8'h01);
        ack = 1'b1; ack_idx = 3'd0;
        tick(1);
        ack = 1'b0;
        check("idle_ack_err", {7'd0, ack_err}, 8'h00);
        check("idle_ack_busy", {7'd0, busy}, 8'h01);
        en = 1'b1;
        tick(1);
        check("en_reoffer", pend_snap, 8'h01);
        ack = 1'b1; ack_idx = 3'd0;
        tick(1);
        ack = 1'b0;
        check("clean5_busy", {7'd0, busy}, 8'h00);
        req = 8'h00;
        tick(5);

`ifdef PE_REQ_OVERFLOW_EN
        en  = 1'b0;
        req = 8'h02;
        tick(4);
        check("ovf_first", ovf, 8'h00);
        req = 8'h00;
        tick(4);
        req = 8'h02;
        tick(4);
        check("ovf_set", ovf, 8'h02);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 8'h00);
        en = 1'b1;
        tick(1);
        check("ovf_offer", pend_snap, 8'h02);
        ack = 1'b1; ack_idx = 3'd1;
        tick(1);
        ack = 1'b0;
        req = 8'h00;
        tick(5);
`endif

        // Asynchronous reset in the middle of an offer.
        req = 8'h08;
        tick(4);
        check("pre_rst_valid", {7'd0, pend_valid}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_snap", pend_snap, 8'h00);
        check("arst_vb", {6'd0, pend_valid, busy}, 8'h00);
        check("arst_pulses", {6'd0, ack_err, timeout}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_req_capture.md
Name: pe_req_capture

Overview:
- Request-capture front end that sits directly upstream of the 8-bit priority encoder.
- Synchronises 8 asynchronous request lines and edge-detects them into sticky pending bits, after masking.
- Offers a frozen snapshot vector to the encoder, with a valid/ack handshake. The consumer returns the serviced index, and only that pending bit is cleared.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per request bit (legal range 2 to 4).
- TIMEOUT_CYCLES, 255, number of OFFER cycles without an ack before the offer is abandoned (legal range 1 to 255; 8-bit counter).

Ports:
- wb_clk_i  input  1  sole clock, rising edge.
- wb_rst_n  input  1  asynchronous, active-low reset.
- io_req  input  8  asynchronous request lines; bit 7 is the highest priority.
- io_mask  input  8  synchronous mask; 1 blocks the bit from the offer but does not stop capture.
- io_en  input  1  block enable; when low, nothing is offered.
- io_ack  input  1  single-cycle service acknowledge from downstream.
- io_ack_idx  input  3  index being acknowledged; sampled only when io_ack=1.
- pend_snap  output  8  frozen masked-pending vector fed to the encoder input.
- pend_valid  output  1  pend_snap is stable and must be serviced.
- ack_err  output  1  one-cycle pulse on an ack whose index is not set in pend_snap.
- timeout  output  1  one-cycle pulse when an offer expires.
- busy  output  1  high when any pending bit is set, regardless of mask.

Behaviour:
- Reset (async assert, sync-release use): all synchroniser flops, pending, pend_snap, the counter and all outputs go to 0. FSM enters IDLE.
- Sync: each io_req bit passes through SYNC_STAGES flops. rise[i] = sync[i] & ~prev[i], with prev registered.
- Pending: pending[i] sets on rise[i] and clears only on a valid ack for index i.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Capture continues in every FSM state, independent of io_en and io_mask.
- masked = pending & ~io_mask.
- FSM has three states.
- IDLE:
  - pend_valid=0.
  - If io_en=1 and masked≠0: pend_snap<=masked, counter<=0, go to OFFER.
- OFFER:
  - pend_valid=1 and pend_snap is held constant.
  - io_en=0: go to IDLE; pend_snap<=0; pending is untouched.
  - Else if io_ack and pend_snap[io_ack_idx]=1: clear pending[io_ack_idx], go to GAP.
  - Else if io_ack and the bit is 0: ack_err pulses, go to GAP, nothing is cleared.
  - Else if counter reaches TIMEOUT_CYCLES-1: timeout pulses, go to GAP, nothing is cleared.
  - Else counter increments.
- GAP:
  - Lasts one cycle; pend_valid=0 and pend_snap<=0, then go to IDLE.
  - This guarantees the encoder sees a deasserted vector between offers.
- Latency: req high → pend_valid high takes SYNC_STAGES+2 clock edges (4 at the default). Ack → next offer takes a minimum of 3 edges (GAP, IDLE, OFFER).
- Mask changes made during OFFER do not alter pend_snap; they take effect on the next IDLE evaluation.
- io_ack outside OFFER is ignored, with no ack_err.
- busy = |pending, registered.

Optional Feature:
- Macro: PE_REQ_OVERFLOW_EN.
- Defined:
  - Adds output ovf (8 bits). ovf[i] sets on rise[i] while pending[i] is already 1 and not being cleared that cycle.
  - Adds input ovf_clr (1 bit); ovf_clr=1 clears all ovf bits, and a same-cycle set wins over the clear.
  - ovf resets to 0.
- Undefined: the ovf and ovf_clr ports do not exist, and a repeated edge on an already-pending bit is silently merged.

Test Plan:
- Reset, then io_req=8'h00, io_en=1 → pend_valid=0, busy=0 and pend_snap=8'h00 for 20 cycles. Assert wb_rst_n low mid-OFFER → all outputs go to 0 immediately, without waiting for a clock edge.
- io_req rises to 8'h24, io_mask=0, no ack → pend_valid=1 four edges later with pend_snap=8'h24. Ack idx=5 → pending becomes 8'h04. After the GAP, a new offer shows pend_snap=8'h04 within 3 edges.
- Offer of 8'h80 with ack idx=3 → ack_err pulses for 1 cycle and pend_valid drops for the GAP. The offer returns as 8'h80 with pending unchanged.
- io_mask=8'hFF with an edge on bit 2 → busy=1 and pend_valid stays 0. Clear the mask to 0 → pend_snap=8'h04 at the next IDLE→OFFER transition.
- TIMEOUT_CYCLES=4 with an offer of 8'h01 and no ack → timeout pulses exactly 4 cycles after pend_valid rises. Re-offer follows; deassert io_en in OFFER → pend_valid=0 on the next edge and busy stays 1.
- PE_REQ_OVERFLOW_EN defined: toggle req bit 1 twice, with each high phase ≥ SYNC_STAGES+1 cycles, before any ack → ovf=8'h02. Pulse ovf_clr → ovf=8'h00.
